key_matrix_scanner: RTL
=======================

// Module: key_matrix_scanner
// PURPOSE
//  Scan controller for the 4x4 key matrix GPIO (btn_key_col / btn_key_row).
//  Drives one column low at a time and samples the rows. Debounces whole
//  scan frames and keeps a 16-bit key_state. Emits one press event per newly
//  pressed key through a valid/ready port to the confreg/GPIO bus side.
//  Key index = row*4 + col.
// PARAMETERS
//  SCAN_DIV        1000  clk cycles each column is driven (dwell); legal >= 4
//  DEBOUNCE_SCANS  4     consecutive identical raw frames needed to accept a frame; legal >= 1
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  resetn       in   1   asynchronous active-low reset
//  scan_en      in   1   1 = scanning enabled
//  btn_key_col  out  4   column drive, active-low, one-hot-low while scanning
//  btn_key_row  in   4   row sense, active-low, asynchronous to clk
//  key_state    out  16  debounced pressed map (bit i = key i held)
//  any_key      out  1   |key_state
//  key_valid    out  1   press event pending
//  key_code     out  4   index of the lowest pending key; valid when key_valid=1
//  key_ready    in   1   consumer accepts event when key_valid & key_ready
// BEHAVIOUR
//  Reset values: btn_key_col=4'b1111, key_state=0, any_key=0, key_valid=0,
//   key_code=0. Internal counters, column index, frames and pending mask = 0.
//  Rows pass through a 2-flop synchronizer (reset 4'b1111) before any use.
//  Divider cnt runs 0..SCAN_DIV-1 while scan_en=1. Column c is driven
//   (btn_key_col = ~(1<<c)) for SCAN_DIV cycles, c = 0,1,2,3, wrapping to 0.
//  At cnt==SCAN_DIV-1 the synced rows are captured into raw[r*4+c] = ~row_s[r]
//   for the current c. In the same cycle c advances and cnt wraps to 0.
//  Frame end = capture of c=3 (one frame every 4*SCAN_DIV cycles). At frame end:
//   - raw==prev_raw: match_cnt <= min(match_cnt+1, DEBOUNCE_SCANS).
//   - otherwise: match_cnt <= 1.
//   - prev_raw <= raw.
//   - If the new match_cnt==DEBOUNCE_SCANS and raw!=key_state:
//     key_state <= raw on the next edge, and pending |= raw & ~key_state.
//   - Releases update key_state only. They generate no event.
//   - With DEBOUNCE_SCANS=1, every frame is accepted.
//  Event port:
//   - key_valid = |pending.
//   - key_code = priority-encoded lowest set pending bit; both come from registers.
//   - key_valid & key_ready clears that bit at the clock edge, giving up to 1 event per cycle.
//   - key_valid/key_code stay stable while key_ready=0.
//   - A pending bit survives a later release of the key; a press is never lost.
//   - Same-cycle set and clear of the same bit: set wins.
//  scan_en=0:
//   - From the next edge: btn_key_col=4'b1111, cnt=0, c=0, match_cnt=0.
//   - The partial raw frame is discarded.
//   - key_state, pending and the event port are retained and continue to operate.
//  scan_en 0->1: scanning restarts at column 0, cnt 0.
//  resetn low at any time: immediately returns to reset values. Pending events are lost.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=2, row model: row[r] low iff key(r,col) held and col low)
//  1 Reset, then resetn=1, scan_en=1 -> btn_key_col 1110,1101,1011,0111, 4 cycles
//    each, repeating. All other outputs stay 0 with no keys held.
//  2 Hold key 6 (row1,col2), key_ready=0 -> after 2nd frame: key_state=16'h0040,
//    any_key=1, key_valid=1, key_code=6, stable for 20 cycles.
//    Pulse key_ready one cycle -> key_valid=0 next cycle.
//  3 Key 6 present in alternate frames only (bounce) -> key_state stays 0, key_valid
//    stays 0. Key held 2 consecutive frames -> accepted.
//  4 Keys 3 and 9 pressed together, key_ready=1 -> key_code 3 then 9 on consecutive
//    cycles, then key_valid=0. key_state=16'h0208.
//  5 Release all keys -> after 2 frames key_state=0 and any_key=0, with no key_valid pulse.
//    Press key 3, release before acceptance, ready=0 -> pending event 3 retained.
//  6 scan_en=0 mid-frame -> btn_key_col=4'b1111 next cycle and key_state unchanged.
//    resetn pulse while key_valid=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/key_matrix_scanner.sv
// 4x4 key matrix scan controller: drives one column low at a time, debounces
// whole scan frames into key_state and queues one press event per new key.
module key_matrix_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scan_en,
  output logic [3:0]  btn_key_col,
  input  logic [3:0]  btn_key_row,
  output logic [15:0] key_state,
  output logic        any_key,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready
);

  localparam int CW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  localparam int MW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } scan_state_t;

  scan_state_t       state, state_next;
  logic [3:0]        row_p0, row_p1;
  logic [CW-1:0]     cnt, cnt_next;
  logic [1:0]        col, col_next;
  logic [3:0]        col_drive_next;
  logic [15:0]       raw, raw_ins, prev_raw;
  logic [MW-1:0]     match_cnt, match_new;
  logic [15:0]       pending, pending_next;
  logic [15:0]       set_mask, clr_mask;
  logic              scan_run, capture, frame_end, accept;

  // Lowest set bit wins so the consumer always sees keys in index order.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

  function automatic logic [MW-1:0] next_match(input logic same, input logic [MW-1:0] m);
    if (!same)
      next_match = MW'(1);
    else if (m >= MATCH_MAX)
      next_match = MATCH_MAX;
    else
      next_match = m + MW'(1);
  endfunction

  // Stage p0/p1: row synchronizer, rows are asynchronous to clk
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_p0 <= 4'b1111;
      row_p1 <= 4'b1111;
    end else begin
      row_p0 <= btn_key_row;
      row_p1 <= row_p0;
    end
  end

  // Scan sequencing: IDLE holds everything at column 0 until scan_en is seen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    col_next       = col;
    col_drive_next = 4'b1111;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        col_next = 2'd0;
        if (scan_en) state_next = S_SCAN;
      end
      S_SCAN: begin
        if (!scan_en) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          col_next   = 2'd0;
        end else if (cnt == CNT_LAST) begin
          cnt_next = '0;
          col_next = col + 2'd1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (scan_en) col_drive_next = ~(4'b0001 << col_next);
  end

  assign scan_run  = scan_en && (state == S_SCAN);
  assign capture   = scan_run && (cnt == CNT_LAST);
  assign frame_end = capture && (col == 2'd3);

  always_comb begin
    raw_ins = raw;
    for (int r = 0; r < 4; r++) begin
      raw_ins[r*4 + int'(col)] = ~row_p1[r];
    end
  end

  // The column drive is registered so the GPIO pins never see decode glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      col         <= 2'd0;
      btn_key_col <= 4'b1111;
    end else begin
      cnt         <= cnt_next;
      col         <= col_next;
      btn_key_col <= col_drive_next;
    end
  end

  // Stage p2: frame assembly and debounce
  assign match_new = next_match(raw_ins == prev_raw, match_cnt);
  assign accept    = frame_end && (match_new == MATCH_MAX) && (raw_ins != key_state);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw       <= '0;
      prev_raw  <= '0;
      match_cnt <= '0;
      key_state <= '0;
    end else begin
      if (!scan_run)   raw <= '0;
      else if (capture) raw <= raw_ins;

      if (!scan_en) begin
        match_cnt <= '0;
      end else if (frame_end) begin
        match_cnt <= match_new;
        prev_raw  <= raw_ins;
      end

      if (accept) key_state <= raw_ins;
    end
  end

  // Event queue: only newly pressed keys are queued; a set beats a same-cycle clear
  assign set_mask     = accept ? (raw_ins & ~key_state) : 16'd0;
  assign clr_mask     = (key_valid && key_ready) ? (16'd1 << key_code) : 16'd0;
  assign pending_next = (pending & ~clr_mask) | set_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pending <= '0;
    else         pending <= pending_next;
  end

  assign key_valid = |pending;
  assign key_code  = lowest_set(pending);
  assign any_key   = |key_state;

endmodule
